shot_renderer: RTL and testbench

- Reads the packed shot slot array produced by asteroids_controller once per frame.
- Erases each shot's previously drawn square, then draws its current square, through a valid/ready pixel-write interface into the framebuffer writer.
- Retires shots that have left the screen by pulsing delete_shot/shot_address back to the controller.

---
 rtl/shot_pkg.sv | 50 +++++
 rtl/square_pixel_gen.sv | 115 +++++++++++
 rtl/shot_renderer.sv | 179 +++++++++++++++++
 tb/tb_shot_renderer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
// Entity field layout, geometry constants and sweep states shared by the
// shot renderer and asteroids_controller.
package shot_pkg;

    localparam int SHOT_COUNT  = 10;
    localparam int ENTITY_SIZE = 34;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

    localparam int ACTIVE_BIT  = 33;
    localparam int TYPE_MSB    = 32;
    localparam int TYPE_LSB    = 30;
    localparam int YQ_MSB      = 29;
    localparam int YQ_LSB      = 28;
    localparam int XQ_MSB      = 27;
    localparam int XQ_LSB      = 26;
    localparam int Y_MSB       = 25;
    localparam int Y_LSB       = 16;
    localparam int X_MSB       = 15;
    localparam int X_LSB       = 6;
    localparam int DIR_MSB     = 5;
    localparam int DIR_LSB     = 0;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_CHK,
        ERASE_PIX,
        DRAW_CHK,
        DRAW_PIX,
        DONE
    } state_e;

    // Only the fields the renderer needs survive the frame snapshot.
    typedef struct packed {
        logic       active;
        logic [2:0] colour;
        logic [9:0] y;
        logic [9:0] x;
    } shot_t;

    function automatic shot_t unpack_shot(input logic [ENTITY_SIZE-1:0] e);
        shot_t s;
        s.active = e[ACTIVE_BIT];
        s.colour = e[TYPE_MSB:TYPE_LSB];
        s.y      = e[Y_MSB:Y_LSB];
        s.x      = e[X_MSB:X_LSB];
        return s;
    endfunction

endpackage

// File: rtl/square_pixel_gen.sv
// Walks one SHOT_SIZE x SHOT_SIZE square (dx fastest), skipping pixels past the
// screen edge, and presents each pixel on a registered valid/ready interface.
module square_pixel_gen #(
    parameter int SHOT_SIZE = 2,
    parameter int SCREEN_W  = shot_pkg::SCREEN_W,
    parameter int SCREEN_H  = shot_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [9:0] origin_x,
    input  logic [9:0] origin_y,
    input  logic [2:0] colour,
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_colour,
    output logic       last_acc
);

    localparam logic [10:0] S11 = 11'(SHOT_SIZE);
    localparam logic [10:0] W11 = 11'(SCREEN_W);
    localparam logic [10:0] H11 = 11'(SCREEN_H);

    // Clipping is monotonic along each axis, so it reduces to a per-axis span.
    function automatic logic [2:0] span(input logic [9:0] org, input logic [10:0] lim);
        logic [10:0] room;
        room = ({1'b0, org} >= lim) ? 11'd0 : lim - {1'b0, org};
        return (room < S11) ? room[2:0] : S11[2:0];
    endfunction

    logic       valid_q,  valid_d;
    logic [9:0] x_q,      x_d;
    logic [9:0] y_q,      y_d;
    logic [2:0] colour_q, colour_d;
    logic [9:0] ox_q,     ox_d;
    logic [2:0] dx_q,     dx_d;
    logic [2:0] dy_q,     dy_d;
    logic [2:0] wlim_q,   wlim_d;
    logic [2:0] hlim_q,   hlim_d;
    logic [2:0] wspan,    hspan;

    always_comb begin
        valid_d  = valid_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        ox_d     = ox_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        wlim_d   = wlim_q;
        hlim_d   = hlim_q;
        last_acc = 1'b0;
        wspan    = span(origin_x, W11);
        hspan    = span(origin_y, H11);

        if (valid_q && pix_ready) begin
            if (dx_q + 3'd1 < wlim_q) begin
                dx_d = dx_q + 3'd1;
                x_d  = x_q + 10'd1;
            end else if (dy_q + 3'd1 < hlim_q) begin
                dx_d = 3'd0;
                dy_d = dy_q + 3'd1;
                x_d  = ox_q;
                y_d  = y_q + 10'd1;
            end else begin
                valid_d  = 1'b0;
                last_acc = 1'b1;
            end
        end

        if (start) begin
            valid_d  = (wspan != 3'd0) && (hspan != 3'd0);
            x_d      = origin_x;
            y_d      = origin_y;
            ox_d     = origin_x;
            colour_d = colour;
            dx_d     = 3'd0;
            dy_d     = 3'd0;
            wlim_d   = wspan;
            hlim_d   = hspan;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            ox_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            wlim_q   <= '0;
            hlim_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            ox_q     <= ox_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            wlim_q   <= wlim_d;
            hlim_q   <= hlim_d;
        end
    end

    assign pix_valid  = valid_q;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign pix_colour = colour_q;

endmodule

// File: rtl/shot_renderer.sv
// Per-frame shot sweep: erase every previously drawn square, draw the current
// ones, and retire shots that have left the screen.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for frame_start; snapshot taken on the pulse
// ERASE_CHK | one cycle per slot; start erase if slot was drawn last frame
// ERASE_PIX | erase square in BG_COLOUR being emitted
// DRAW_CHK  | one cycle per slot; skip, retire, or start draw
// DRAW_PIX  | draw square in the shot's colour being emitted
// DONE      | frame_done pulse, back to IDLE
module shot_renderer #(
    parameter int         SHOT_COUNT  = shot_pkg::SHOT_COUNT,
    parameter int         ENTITY_SIZE = shot_pkg::ENTITY_SIZE,
    parameter int         SCREEN_W    = shot_pkg::SCREEN_W,
    parameter int         SCREEN_H    = shot_pkg::SCREEN_H,
    parameter int         SHOT_SIZE   = 2,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter int         ADDR_W      = $clog2(SHOT_COUNT)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  frame_start,
    input  logic [SHOT_COUNT-1:0][ENTITY_SIZE-1:0] shots_data,
    input  logic                                  pix_ready,
    output logic                                  pix_valid,
    output logic [9:0]                            pix_x,
    output logic [9:0]                            pix_y,
    output logic [2:0]                            pix_colour,
    output logic                                  delete_shot,
    output logic [ADDR_W-1:0]                     shot_address,
    output logic                                  busy,
    output logic                                  frame_done
);
    import shot_pkg::*;

    localparam logic [10:0]       W11       = 11'(SCREEN_W);
    localparam logic [10:0]       H11       = 11'(SCREEN_H);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(SHOT_COUNT - 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       slot_q, slot_d;
    shot_t                   snap_q [SHOT_COUNT];
    shot_t                   snap_d [SHOT_COUNT];
    logic [SHOT_COUNT-1:0]   prev_valid_q, prev_valid_d;
    logic [9:0]              prev_x_q [SHOT_COUNT];
    logic [9:0]              prev_x_d [SHOT_COUNT];
    logic [9:0]              prev_y_q [SHOT_COUNT];
    logic [9:0]              prev_y_d [SHOT_COUNT];

    shot_t      cur;
    logic       last_slot;
    logic       off_screen;
    logic       gen_start;
    logic [9:0] gen_x, gen_y;
    logic [2:0] gen_colour;
    logic       gen_last;
    logic       unused_fields;

    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < SHOT_COUNT; i++) begin
            unused_fields = unused_fields ^ (^shots_data[i][YQ_MSB:XQ_LSB])
                                          ^ (^shots_data[i][DIR_MSB:DIR_LSB]);
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        snap_d       = snap_q;
        prev_valid_d = prev_valid_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        gen_start    = 1'b0;
        gen_x        = '0;
        gen_y        = '0;
        gen_colour   = '0;
        delete_shot  = 1'b0;
        shot_address = '0;
        busy         = 1'b0;
        frame_done   = 1'b0;
        cur          = snap_q[slot_q];
        last_slot    = (slot_q == LAST_SLOT);
        off_screen   = ({1'b0, cur.x} >= W11) || ({1'b0, cur.y} >= H11);

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    for (int i = 0; i < SHOT_COUNT; i++) begin
                        snap_d[i] = unpack_shot(shots_data[i]);
                    end
                    slot_d  = '0;
                    state_d = ERASE_CHK;
                end
            end
            ERASE_CHK, ERASE_PIX: begin
                busy = 1'b1;
                if (state_q == ERASE_CHK && prev_valid_q[slot_q]) begin
                    gen_start  = 1'b1;
                    gen_x      = prev_x_q[slot_q];
                    gen_y      = prev_y_q[slot_q];
                    gen_colour = BG_COLOUR;
                    state_d    = ERASE_PIX;
                end else if (state_q == ERASE_CHK || gen_last) begin
                    state_d = last_slot ? DRAW_CHK : ERASE_CHK;
                    slot_d  = last_slot ? '0 : slot_q + ADDR_W'(1);
                end
            end
            DRAW_CHK, DRAW_PIX: begin
                busy = 1'b1;
                if (state_q == DRAW_CHK && cur.active && !off_screen) begin
                    prev_valid_d[slot_q] = 1'b1;
                    prev_x_d[slot_q]     = cur.x;
                    prev_y_d[slot_q]     = cur.y;
                    gen_start            = 1'b1;
                    gen_x                = cur.x;
                    gen_y                = cur.y;
                    gen_colour           = cur.colour;
                    state_d              = DRAW_PIX;
                end else if (state_q == DRAW_CHK || gen_last) begin
                    if (state_q == DRAW_CHK) begin
                        prev_valid_d[slot_q] = 1'b0;
                        // Off-screen includes x/y that wrapped to 1023 on decrement.
                        delete_shot  = cur.active;
                        shot_address = cur.active ? slot_q : '0;
                    end
                    state_d = last_slot ? DONE : DRAW_CHK;
                    slot_d  = last_slot ? '0 : slot_q + ADDR_W'(1);
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            prev_valid_q <= '0;
            for (int i = 0; i < SHOT_COUNT; i++) begin
                snap_q[i]   <= '0;
                prev_x_q[i] <= '0;
                prev_y_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            prev_valid_q <= prev_valid_d;
            snap_q       <= snap_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
        end
    end

    square_pixel_gen #(
        .SHOT_SIZE (SHOT_SIZE),
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H)
    ) u_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (gen_start),
        .origin_x   (gen_x),
        .origin_y   (gen_y),
        .colour     (gen_colour),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .last_acc   (gen_last)
    );

endmodule

// File: tb/tb_shot_renderer.sv
// Scoreboard bench: a frame model queues expected beats and retire addresses,
// monitors pop and compare as the renderer produces them.
module tb_shot_renderer;
    localparam int N = 10;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 frame_start = 1'b0;
    logic                 pix_ready = 1'b1;
    logic [N-1:0][33:0]   shots_data = '0;
    logic                 pix_valid;
    logic [9:0]           pix_x, pix_y;
    logic [2:0]           pix_colour;
    logic                 delete_shot;
    logic [3:0]           shot_address;
    logic                 busy, frame_done;

    shot_renderer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .shots_data   (shots_data),
        .pix_ready    (pix_ready),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_colour   (pix_colour),
        .delete_shot  (delete_shot),
        .shot_address (shot_address),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    logic [22:0] exp_q[$];
    logic [3:0]  del_q[$];
    int          frame_beats, frame_dels, exp_beats, exp_dels;
    bit          m_pv[N];
    logic [9:0]  m_px[N], m_py[N];
    logic        prev_stall = 1'b0;
    logic [22:0] held;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_valid", pix_valid, 1);
                check_val("hold_data", {pix_x, pix_y, pix_colour}, held);
            end
            if (pix_valid && pix_ready) begin
                frame_beats++;
                if (exp_q.size() == 0) check_val("beat_extra", exp_q.size(), 1);
                else check_val("beat", {pix_x, pix_y, pix_colour}, exp_q.pop_front());
            end
            prev_stall = pix_valid && !pix_ready;
            held       = {pix_x, pix_y, pix_colour};
            if (delete_shot) begin
                frame_dels++;
                if (del_q.size() == 0) check_val("del_extra", del_q.size(), 1);
                else check_val("del_addr", shot_address, del_q.pop_front());
            end
        end
    end

    function automatic logic [33:0] ent(input logic a, input logic [2:0] c,
                                        input logic [9:0] y, input logic [9:0] x);
        return {a, c, 4'b0000, y, x, 6'b000000};
    endfunction

    task automatic push_square(input int x, input int y, input logic [2:0] c);
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (x + dx < 640 && y + dy < 480) begin
                    exp_q.push_back({10'(x + dx), 10'(y + dy), c});
                    exp_beats++;
                end
    endtask

    task automatic model_frame(input logic [N-1:0][33:0] s);
        exp_beats = 0;
        exp_dels  = 0;
        for (int i = 0; i < N; i++)
            if (m_pv[i]) push_square(int'(m_px[i]), int'(m_py[i]), 3'b000);
        for (int i = 0; i < N; i++) begin
            if (!s[i][33]) begin
                m_pv[i] = 1'b0;
            end else if (s[i][15:6] >= 10'd640 || s[i][25:16] >= 10'd480) begin
                del_q.push_back(4'(i));
                exp_dels++;
                m_pv[i] = 1'b0;
            end else begin
                m_pv[i] = 1'b1;
                m_px[i] = s[i][15:6];
                m_py[i] = s[i][25:16];
                push_square(int'(m_px[i]), int'(m_py[i]), s[i][32:30]);
            end
        end
    endtask

    task automatic run_frame(input logic [N-1:0][33:0] s, input int stall_at, input int pulse_at,
                             input bit rst_draw, output int cycles, output int busy_cnt);
        logic [N-1:0][33:0] alt;
        model_frame(s);
        frame_beats = 0;
        frame_dels  = 0;
        cycles      = 0;
        busy_cnt    = 0;
        @(posedge clk); #1;
        shots_data  = s;
        frame_start = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk); #1;
            cycles = n;
            if (n == 1) frame_start = 1'b0;
            if (n == stall_at) pix_ready = 1'b0;
            if (n == stall_at + 5) pix_ready = 1'b1;
            if (n == pulse_at) begin
                alt = s;
                alt[0][15:6] = 10'd400;
                shots_data  = alt;
                frame_start = 1'b1;
            end
            if (n == pulse_at + 1) frame_start = 1'b0;
            if (rst_draw && pix_valid && pix_colour != 3'b000) begin
                reset_n = 1'b0;
                #1;
                check_val("rst_valid", pix_valid, 0);
                check_val("rst_busy", busy, 0);
                check_val("rst_done", frame_done, 0);
                exp_q.delete();
                del_q.delete();
                for (int i = 0; i < N; i++) m_pv[i] = 1'b0;
                return;
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (frame_done) break;
            if (n == 600) check_val("frame_timeout", frame_done, 1);
        end
        check_val("beat_count", frame_beats, exp_beats);
        check_val("del_count", frame_dels, exp_dels);
        check_val("beats_left", exp_q.size(), 0);
        check_val("dels_left", del_q.size(), 0);
    endtask

    initial begin
        logic [N-1:0][33:0] s;
        int cyc, bc, extra_done, extra_busy;
        s = '0;
        for (int i = 0; i < N; i++) m_pv[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pix_valid", pix_valid, 0);
        check_val("rst_busy0", busy, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_delete", delete_shot, 0);
        check_val("rst_pix_xy", {pix_x, pix_y}, 0);
        reset_n = 1'b1;

        run_frame(s, -100, -100, 1'b0, cyc, bc);
        check_val("done_cycle", cyc, 21);
        check_val("busy_cycles", bc, 20);

        s[0] = ent(1'b1, 3'b101, 10'd100, 10'd200);
        run_frame(s, -100, -100, 1'b0, cyc, bc);

        s[0] = ent(1'b1, 3'b101, 10'd100, 10'd202);
        run_frame(s, -100, -100, 1'b0, cyc, bc);

        s[1] = ent(1'b1, 3'b011, 10'd479, 10'd639);
        s[3] = ent(1'b1, 3'b010, 10'd50, 10'd1023);
        run_frame(s, -100, -100, 1'b0, cyc, bc);

        s[3] = '0;
        run_frame(s, 3, -100, 1'b0, cyc, bc);

        run_frame(s, -100, 5, 1'b0, cyc, bc);
        extra_done = 0;
        extra_busy = 0;
        repeat (30) begin
            @(negedge clk);
            if (frame_done) extra_done++;
            if (busy) extra_busy++;
        end
        check_val("extra_done", extra_done, 0);
        check_val("extra_busy", extra_busy, 0);

        s    = '0;
        s[0] = ent(1'b1, 3'b101, 10'd200, 10'd300);
        run_frame(s, -100, -100, 1'b1, cyc, bc);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_frame(s, -100, -100, 1'b0, cyc, bc);
        check_val("done_cycle_post_rst", cyc, 25);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
